// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: address-width helper, default thresholds and the
// per-cycle operation encoding. Intended for reuse by the async FIFO as well.
package fifo_pkg;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_DEPTH     = 16;
  localparam int DEF_AE_LEVEL  = 2;
  localparam int DEF_AF_MARGIN = 2;

  // Encoded as {read_accepted, write_accepted} so the cast below is direct.
  typedef enum logic [1:0] {
    OP_IDLE  = 2'b00,
    OP_WRITE = 2'b01,
    OP_READ  = 2'b10,
    OP_BOTH  = 2'b11
  } fifo_op_e;

  // Ceiling log2, evaluated at elaboration time for address widths.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic fifo_op_e fifo_op(input logic wr_acc, input logic rd_acc);
    return fifo_op_e'({rd_acc, wr_acc});
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port FIFO storage: synchronous write, asynchronous read.
module fifo_mem #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // NOTE: storage has no reset so it maps onto RAM; the pointers guarantee
  // no location is read before it has been written.
  always_ff @(posedge clk) begin
    if (wr_en) r_mem[wr_addr] <= wr_data;
  end

  assign rd_data = r_mem[rd_addr];

endmodule

// File: rtl/sync_fifo_flex.sv
// Parametrised single-clock FIFO with optional first-word-fall-through,
// programmable almost thresholds, occupancy count and sticky error flags.
module sync_fifo_flex
  import fifo_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = DEPTH - DEF_AF_MARGIN,
  parameter int AE_LEVEL = DEF_AE_LEVEL,
  parameter bit FWFT     = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   rd_valid,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [clog2(DEPTH):0]  count,
  input  logic                   err_clr,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int ADDR_W = clog2(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;
  localparam logic [CNT_W-1:0] AF_THR = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_THR = CNT_W'(AE_LEVEL);

  logic [CNT_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_overflow;
  logic             r_underflow;

  logic             w_full;
  logic             w_empty;
  logic             w_wr_acc;
  logic             w_rd_acc;
  fifo_op_e         w_op;
  logic [WIDTH-1:0] w_head;

  // Same low bits with opposite wrap bits means the writer is one lap ahead.
  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_full   = (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]) &&
                    (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]);
  assign w_wr_acc = wr_en && !w_full;
  assign w_rd_acc = rd_en && !w_empty;
  assign w_op     = fifo_op(w_wr_acc, w_rd_acc);

  fifo_mem #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (w_wr_acc),
    .wr_addr (r_wr_ptr[ADDR_W-1:0]),
    .wr_data (wr_data),
    .rd_addr (r_rd_ptr[ADDR_W-1:0]),
    .rd_data (w_head)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
      case (w_op)
        OP_WRITE: r_count <= r_count + 1'b1;
        OP_READ:  r_count <= r_count - 1'b1;
        default:  r_count <= r_count;
      endcase
    end
  end

  // A new rejection outranks a clear arriving in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (wr_en && w_full)      r_overflow <= 1'b1;
      else if (err_clr)         r_overflow <= 1'b0;

      if (rd_en && w_empty)     r_underflow <= 1'b1;
      else if (err_clr)         r_underflow <= 1'b0;
    end
  end

  generate
    if (FWFT) begin : g_fwft
      // Head word is presented as soon as it exists; rd_en only pops it.
      assign rd_valid = !w_empty;
      assign rd_data  = w_empty ? '0 : w_head;
    end else begin : g_std
      logic [WIDTH-1:0] r_rd_data;
      logic             r_rd_valid;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_rd_data  <= '0;
          r_rd_valid <= 1'b0;
        end else begin
          r_rd_valid <= w_rd_acc;
          if (w_rd_acc) r_rd_data <= w_head;
        end
      end

      assign rd_valid = r_rd_valid;
      assign rd_data  = r_rd_data;
    end
  endgenerate

  assign full         = w_full;
  assign empty        = w_empty;
  assign count        = r_count;
  assign almost_full  = (r_count >= AF_THR);
  assign almost_empty = (r_count <= AE_THR);
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Bench for sync_fifo_flex: a standard and an FWFT instance driven with the
// same stimulus and compared against a queue-based reference model.
module tb_sync_fifo_flex;

  localparam int DEPTH = 4;
  localparam int WIDTH = 8;
  localparam int AF_L  = DEPTH - 2;
  localparam int AE_L  = 2;

  logic             clk;
  logic             rst_n;
  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             rd_en;
  logic             err_clr;

  logic [WIDTH-1:0] s_rd_data, f_rd_data;
  logic             s_rd_valid, f_rd_valid;
  logic             s_full, f_full, s_empty, f_empty;
  logic             s_af, f_af, s_ae, f_ae;
  logic [2:0]       s_count, f_count;
  logic             s_ovf, f_ovf, s_unf, f_unf;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [WIDTH-1:0] q[$];
  logic             ovf_m, unf_m;
  logic [WIDTH-1:0] std_data_m;
  logic             std_valid_m;

  sync_fifo_flex #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FWFT(1'b0)) u_std (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(s_rd_data), .rd_valid(s_rd_valid), .full(s_full), .empty(s_empty),
    .almost_full(s_af), .almost_empty(s_ae), .count(s_count),
    .err_clr(err_clr), .overflow(s_ovf), .underflow(s_unf)
  );

  sync_fifo_flex #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FWFT(1'b1)) u_fwft (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(f_rd_data), .rd_valid(f_rd_valid), .full(f_full), .empty(f_empty),
    .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
    .err_clr(err_clr), .overflow(f_ovf), .underflow(f_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    ovf_m       = 1'b0;
    unf_m       = 1'b0;
    std_data_m  = '0;
    std_valid_m = 1'b0;
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    check("s_count", 32'(s_count), 32'(n));
    check("f_count", 32'(f_count), 32'(n));
    check("s_full",  32'(s_full),  32'(n == DEPTH));
    check("f_full",  32'(f_full),  32'(n == DEPTH));
    check("s_empty", 32'(s_empty), 32'(n == 0));
    check("f_empty", 32'(f_empty), 32'(n == 0));
    check("s_af",    32'(s_af),    32'(n >= AF_L));
    check("f_af",    32'(f_af),    32'(n >= AF_L));
    check("s_ae",    32'(s_ae),    32'(n <= AE_L));
    check("f_ae",    32'(f_ae),    32'(n <= AE_L));
    check("s_ovf",   32'(s_ovf),   32'(ovf_m));
    check("f_ovf",   32'(f_ovf),   32'(ovf_m));
    check("s_unf",   32'(s_unf),   32'(unf_m));
    check("f_unf",   32'(f_unf),   32'(unf_m));
    check("s_valid", 32'(s_rd_valid), 32'(std_valid_m));
    check("s_data",  32'(s_rd_data),  32'(std_data_m));
    check("f_valid", 32'(f_rd_valid), 32'(n != 0));
    if (n != 0) check("f_data", 32'(f_rd_data), 32'(q[0]));
  endtask

  // One clock of stimulus; model follows the occupancy rules directly.
  task automatic step(input logic wr, input logic [WIDTH-1:0] d,
                      input logic rd, input logic clr);
    logic was_full, was_empty;
    wr_en   = wr;
    wr_data = d;
    rd_en   = rd;
    err_clr = clr;
    @(posedge clk);
    was_full    = (q.size() == DEPTH);
    was_empty   = (q.size() == 0);
    std_valid_m = rd && !was_empty;
    if (std_valid_m) std_data_m = q.pop_front();
    if (wr && !was_full) q.push_back(d);
    if (wr && was_full) ovf_m = 1'b1;
    else if (clr)       ovf_m = 1'b0;
    if (rd && was_empty) unf_m = 1'b1;
    else if (clr)        unf_m = 1'b0;
    #1;
    check_all();
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    err_clr = 1'b0;
  endtask

  initial begin
    wr_en   = 1'b0;
    wr_data = '0;
    rd_en   = 1'b0;
    err_clr = 1'b0;
    rst_n   = 1'b0;
    model_reset();
    #12;
    check_all();
    check("rst_s_data", 32'(s_rd_data), 32'h0);
    check("rst_f_valid", 32'(f_rd_valid), 32'h0);
    rst_n = 1'b1;

    // Fill to full
    step(1'b1, 8'h11, 1'b0, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b0);
    step(1'b1, 8'h33, 1'b0, 1'b0);
    check("tp_af_3rd", 32'(s_af), 32'h1);
    step(1'b1, 8'h44, 1'b0, 1'b0);
    check("tp_full", 32'(s_full), 32'h1);
    check("tp_count4", 32'(s_count), 32'h4);

    // Write + read while full: read wins, write rejected
    step(1'b1, 8'h55, 1'b1, 1'b0);
    check("tp_ovf_data", 32'(s_rd_data), 32'h11);
    check("tp_ovf_flag", 32'(s_ovf), 32'h1);
    check("tp_ovf_cnt", 32'(s_count), 32'h3);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("tp_ovf_clr", 32'(s_ovf), 32'h0);

    // Drain in order
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("tp_rd_22", 32'(s_rd_data), 32'h22);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("tp_rd_33", 32'(s_rd_data), 32'h33);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("tp_rd_44", 32'(s_rd_data), 32'h44);
    check("tp_empty", 32'(s_empty), 32'h1);

    // Write + read while empty: write wins, read rejected
    step(1'b1, 8'hA5, 1'b1, 1'b0);
    check("tp_unf_flag", 32'(s_unf), 32'h1);
    check("tp_unf_cnt", 32'(s_count), 32'h1);
    check("tp_unf_valid", 32'(s_rd_valid), 32'h0);
    check("tp_fwft_a5", 32'(f_rd_data), 32'hA5);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    check("tp_rd_a5", 32'(s_rd_data), 32'hA5);

    // FWFT fall-through without rd_en, then pop
    step(1'b1, 8'h5A, 1'b0, 1'b0);
    check("tp_fwft_valid", 32'(f_rd_valid), 32'h1);
    check("tp_fwft_data", 32'(f_rd_data), 32'h5A);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("tp_fwft_empty", 32'(f_empty), 32'h1);

    // Steady state at count 2 across pointer wraps
    step(1'b1, 8'h60, 1'b0, 1'b0);
    step(1'b1, 8'h61, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 8'(8'h70 + i), 1'b1, 1'b0);
      check("tp_wrap_cnt", 32'(s_count), 32'h2);
    end
    check("tp_wrap_last", 32'(s_rd_data), 32'h77);

    // Reach count 3 with overflow set and a read in flight, then reset
    step(1'b1, 8'h80, 1'b0, 1'b0);
    step(1'b1, 8'h81, 1'b0, 1'b0);
    step(1'b1, 8'h82, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("tp_pre_rst_cnt", 32'(s_count), 32'h3);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("tp_rst_cnt", 32'(s_count), 32'h0);
    check("tp_rst_empty", 32'(s_empty), 32'h1);
    check("tp_rst_valid", 32'(s_rd_valid), 32'h0);
    check("tp_rst_ovf", 32'(s_ovf), 32'h0);
    check_all();
    #2;
    rst_n = 1'b1;

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 99) < 55), 8'($urandom),
           1'($urandom_range(0, 99) < 45), 1'($urandom_range(0, 15) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_fifo_flex.md
# sync_fifo_flex

Parametrised single-clock FIFO, the general-purpose buffering primitive for datapath blocks that need elastic storage between a producer and a consumer in the same clock domain. Adds configurable width and depth, a first-word-fall-through (FWFT) mode, programmable almost-full/almost-empty thresholds, an occupancy count, and sticky overflow/underflow error flags.

## Interface
- WIDTH, 8, data width in bits (≥1)
- DEPTH, 16, entries; power of two, ≥2
- AF_LEVEL, DEPTH-2, almost_full asserts when count ≥ AF_LEVEL
- AE_LEVEL, 2, almost_empty asserts when count ≤ AE_LEVEL
- FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- wr_en  in  1  write request
- wr_data  in  WIDTH  write data
- rd_en  in  1  read request (FWFT: pop/acknowledge of head word)
- rd_data  out  WIDTH  read data
- rd_valid  out  1  rd_data holds a valid word
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AF_LEVEL
- almost_empty  out  1  count ≤ AE_LEVEL
- count  out  ADDR_W+1  occupancy, ADDR_W = log2(DEPTH)
- err_clr  in  1  synchronous clear of sticky error flags
- overflow  out  1  sticky: write attempted while full
- underflow  out  1  sticky: read attempted while empty

## Operation
- Pointers wr_ptr, rd_ptr are ADDR_W+1 bits; low ADDR_W bits address storage, MSB is wrap bit. empty = pointers equal; full = low bits equal, MSB differs.
- Write accepted iff wr_en && !full; stores wr_data at wr_ptr, wr_ptr += 1 (natural wrap at 2^(ADDR_W+1)).
- Read accepted iff rd_en && !empty; rd_ptr += 1.
- full/empty evaluated on state at start of cycle: read+write on full → read accepted, write rejected, overflow set. Read+write on empty → write accepted, read rejected, underflow set. Read+write otherwise → both accepted, count unchanged.
- count: +1 on write-only, −1 on read-only, unchanged on both/neither. Registered, never exceeds DEPTH.
- almost_full/almost_empty, full, empty derived combinationally from registered count/pointers.
- overflow/underflow: set on rejected request, hold until err_clr; set wins over err_clr in the same cycle.
- Standard mode (FWFT=0): accepted read loads rd_data from head next edge; rd_valid high exactly the cycle after an accepted read; rd_data holds last value otherwise.
- FWFT mode: rd_data = head entry combinationally from storage; rd_valid = !empty; rd_en acknowledges and advances.
- Storage not reset; contents undefined until written.

## Timing
- Reset (async assert, sync-to-clk deassert expected externally): pointers 0, count 0, empty 1, full 0, almost_empty 1, almost_full 0, rd_data 0, rd_valid 0, overflow 0, underflow 0.
- Write-to-empty deassertion: 1 cycle (edge after accepted write). FWFT: word visible on rd_data in that same following cycle.
- Standard read latency: 1 cycle from accepted rd_en to rd_valid/rd_data.
- Full asserts on the edge accepting the DEPTH-th write; deasserts the edge after an accepted read.
- Reset mid-operation: all state returns to reset values immediately; in-flight read discarded (rd_valid 0).

## Structure
- Shared package fifo_pkg: clog2 function for ADDR_W, default threshold constants; reused by future async FIFO.
- Sub-module fifo_mem: DEPTH×WIDTH simple dual-port storage, synchronous write, asynchronous read; control/flags in top.

## Test plan
- DEPTH=4, WIDTH=8, FWFT=0: write 0x11,0x22,0x33,0x44 → full=1, count=4, almost_full=1 after 3rd write; read 4 → data 0x11..0x44 in order, each 1 cycle after rd_en, empty=1.
- Full FIFO, wr_en+rd_en same cycle → read returns 0x11, write rejected, overflow=1, count=3; err_clr → overflow=0.
- Empty FIFO, wr_en(0xA5)+rd_en → underflow=1, count=1, rd_valid=0; next read returns 0xA5.
- FWFT=1: write 0x5A to empty → next cycle rd_valid=1, rd_data=0x5A without rd_en; rd_en → empty=1.
- 10 interleaved write/read pairs at count=2 (pointer wrap twice) → data order preserved, count stays 2.
- rst_n low mid-stream with count=3 → immediately count=0, empty=1, rd_valid=0, flags cleared.
